// File: rtl/sched_delay_pkg.sv
// rtl/sched_delay_pkg.sv - delay classes and class-to-cycle mapping for sched_delay_reg
// Contents: dly_class_e (request delay class), dly_cycles() (class -> cycle count).
package sched_delay_pkg;

  typedef enum logic [1:0] {
    DLY_MIN  = 2'd0,
    DLY_TYP  = 2'd1,
    DLY_MAX  = 2'd2,
    DLY_ZERO = 2'd3
  } dly_class_e;

  function automatic int unsigned dly_cycles(input dly_class_e  cls,
                                             input int unsigned min_dly,
                                             input int unsigned typ_dly,
                                             input int unsigned max_dly);
    case (cls)
      DLY_MIN: return min_dly;
      DLY_TYP: return typ_dly;
      DLY_MAX: return max_dly;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sched_delay_slot.sv
// rtl/sched_delay_slot.sv - one pending-update slot: occupancy, countdown, data, age tag
// Ports:
//   clk, reset        clock, synchronous active-high reset (frees the slot)
//   load_i            claim this slot on this edge (only asserted while free)
//   load_cnt_i        countdown start value (class delay - 1)
//   load_data_i       data to commit on expiry
//   load_tag_i        age tag of the accept
//   occupied_o        slot holds a pending update
//   expire_o          slot commits and frees on the coming edge
//   data_o, tag_o     stored data and age tag
module sched_delay_slot
  import sched_delay_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [TAG_W-1:0] load_tag_i,
  output logic             occupied_o,
  output logic             expire_o,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign occupied_o = occ_q;
  assign expire_o   = occ_q && (cnt_q == '0);
  assign data_o     = data_q;
  assign tag_o      = tag_q;

  always_comb begin
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (load_i) begin
      occ_d  = 1'b1;
      cnt_d  = load_cnt_i;
      data_d = load_data_i;
      tag_d  = load_tag_i;
    end else if (occ_q) begin
      // Count reaches 0 and holds there; the slot frees on that edge.
      if (cnt_q == '0) occ_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: rtl/sched_delay_reg.sv
// rtl/sched_delay_reg.sv - cycle model of a delayed register assign (value = #(min:typ:max) data)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready = pending_cnt < DEPTH
//   req_data, req_sel     data and delay class (0=MIN 1=TYP 2=MAX 3=ZERO)
//   value, value_valid    committed register and "committed since reset" flag
//   upd_pulse             high for the cycle after any commit edge
//   pending_cnt           number of occupied slots
module sched_delay_reg
  import sched_delay_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_DLY = 2,
  parameter int unsigned TYP_DLY = 10,
  parameter int unsigned MAX_DLY = 17,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  input  logic [1:0]                 req_sel,
  output logic [WIDTH-1:0]           value,
  output logic                       value_valid,
  output logic                       upd_pulse,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  // Two updates expiring together were accepted at most MAX_DLY-MIN_DLY edges
  // apart (one accept per edge), so 2^(CNT_W+1) tags keep the half-range
  // age comparison unambiguous.
  localparam int unsigned TAG_W = CNT_W + 1;

  if (MAX_DLY > (1 << CNT_W) - 1) begin : g_cnt_w_check
    $error("sched_delay_reg: CNT_W too narrow for MAX_DLY");
  end
  if (MIN_DLY == 0 || TYP_DLY == 0) begin : g_dly_check
    $error("sched_delay_reg: slot-using delay classes need at least one cycle");
  end

  logic [DEPTH-1:0] occ, expire, load;
  logic [WIDTH-1:0] slot_data [DEPTH];
  logic [TAG_W-1:0] slot_tag  [DEPTH];

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             vv_q, vv_d;
  logic             upd_q, upd_d;
  logic [PW-1:0]    pend_q, pend_d;

  dly_class_e       cls;
  logic             accept, is_zero;
  logic [CNT_W-1:0] load_cnt;
  logic             sel_hit;
  logic [WIDTH-1:0] sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic [PW-1:0]    n_free;

  // a is younger than b when a-b lies in the lower half of the tag space.
  function automatic logic younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[TAG_W-1];
  endfunction

  assign cls       = dly_class_e'(req_sel);
  assign req_ready = (pend_q < PW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign is_zero   = (cls == DLY_ZERO);
  assign load_cnt  = CNT_W'(dly_cycles(cls, MIN_DLY, TYP_DLY, MAX_DLY) - 1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    sched_delay_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TAG_W(TAG_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load[i]),
      .load_cnt_i (load_cnt),
      .load_data_i(req_data),
      .load_tag_i (tag_q),
      .occupied_o (occ[i]),
      .expire_o   (expire[i]),
      .data_o     (slot_data[i]),
      .tag_o      (slot_tag[i])
    );
  end

  // First-free allocator: scanning downward leaves the lowest free index.
  // A slot expiring this edge still reads occupied, so it is reused next cycle.
  always_comb begin
    load = '0;
    if (accept && !is_zero) begin
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (!occ[i]) begin
          load    = '0;
          load[i] = 1'b1;
        end
      end
    end
  end

  // Youngest-expiring selector and freed-slot count.
  always_comb begin
    sel_hit  = 1'b0;
    sel_data = '0;
    sel_tag  = '0;
    n_free   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (expire[i]) begin
        n_free = n_free + PW'(1);
        if (!sel_hit || younger(slot_tag[i], sel_tag)) begin
          sel_hit  = 1'b1;
          sel_data = slot_data[i];
          sel_tag  = slot_tag[i];
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    vv_d    = vv_q;
    upd_d   = 1'b0;
    tag_d   = tag_q;
    if (accept) tag_d = tag_q + 1'b1;
    // A ZERO accept is younger than anything expiring on the same edge.
    if (accept && is_zero) begin
      value_d = req_data;
      vv_d    = 1'b1;
      upd_d   = 1'b1;
    end else if (sel_hit) begin
      value_d = sel_data;
      vv_d    = 1'b1;
      upd_d   = 1'b1;
    end
    pend_d = pend_q + PW'(|load) - n_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      upd_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      tag_q   <= tag_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      upd_q   <= upd_d;
      pend_q  <= pend_d;
    end
  end

  assign value       = value_q;
  assign value_valid = vv_q;
  assign upd_pulse   = upd_q;
  assign pending_cnt = pend_q;

endmodule

// File: tb/tb_sched_delay_reg.sv
// tb/tb_sched_delay_reg.sv - self-checking bench for sched_delay_reg
module tb_sched_delay_reg;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_data = '0;
  logic [1:0] req_sel = '0;
  logic [3:0] value;
  logic       value_valid;
  logic       upd_pulse;
  logic [2:0] pending_cnt;

  sched_delay_reg dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_sel    (req_sel),
    .value      (value),
    .value_valid(value_valid),
    .upd_pulse  (upd_pulse),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: list of pending updates with absolute due edge and
  // an unbounded accept sequence number; younger = larger sequence number.
  int cyc = 0;
  int seq = 0;
  int pq_due[$];
  int pq_data[$];
  int pq_age[$];
  int m_value = 0;
  int m_vv = 0;
  int m_upd = 0;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [1:0] s;
    int         ev;
    int         evv;
    int         eupd;
    int         epend;
  } vec_t;

  vec_t tbl[12];

  function automatic int dly(input logic [1:0] s);
    case (s)
      2'd0:    return 2;
      2'd1:    return 10;
      2'd2:    return 17;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pq_due.delete();
    pq_data.delete();
    pq_age.delete();
    m_value = 0;
    m_vv = 0;
    m_upd = 0;
    cyc = 0;
    chk("rst_value", int'(value), 0);
    chk("rst_value_valid", int'(value_valid), 0);
    chk("rst_upd_pulse", int'(upd_pulse), 0);
    chk("rst_pending_cnt", int'(pending_cnt), 0);
    chk("rst_req_ready", int'(req_ready), 1);
  endtask

  // Drive one request for one edge, advance the model, compare all outputs.
  task automatic step(input logic v, input logic [3:0] d, input logic [1:0] s, output bit acc);
    int  best_age;
    int  best_val;
    bit  hit;
    req_valid = v;
    req_data = d;
    req_sel = s;
    chk("req_ready", int'(req_ready), (pq_due.size() < DEPTH) ? 1 : 0);
    acc = v && (pq_due.size() < DEPTH);
    @(posedge clk);
    hit = 1'b0;
    best_age = -1;
    best_val = 0;
    for (int i = pq_due.size() - 1; i >= 0; i--) begin
      if (pq_due[i] == cyc) begin
        if (pq_age[i] > best_age) begin
          best_age = pq_age[i];
          best_val = pq_data[i];
        end
        hit = 1'b1;
        pq_due.delete(i);
        pq_data.delete(i);
        pq_age.delete(i);
      end
    end
    if (acc) begin
      if (s == 2'd3) begin
        hit = 1'b1;
        best_val = int'(d);
      end else begin
        pq_due.push_back(cyc + dly(s));
        pq_data.push_back(int'(d));
        pq_age.push_back(seq);
      end
      seq++;
    end
    if (hit) begin
      m_value = best_val;
      m_vv = 1;
    end
    m_upd = hit ? 1 : 0;
    cyc++;
    #1;
    req_valid = 1'b0;
    chk("value", int'(value), m_value);
    chk("value_valid", int'(value_valid), m_vv);
    chk("upd_pulse", int'(upd_pulse), m_upd);
    chk("pending_cnt", int'(pending_cnt), pq_due.size());
  endtask

  initial begin
    bit         acc;
    bit         hold;
    int         pulses;
    int         n_acc;
    int         edge5;
    logic       rv;
    logic [3:0] rd;
    logic [1:0] rs;

    do_reset();

    // 5/TYP accepted on edge 0: invisible through edge 9, committed on edge 10.
    tbl[0] = '{1'b1, 4'd5, 2'd1, 0, 0, 0, 1};
    for (int i = 1; i <= 9; i++) tbl[i] = '{1'b0, 4'd0, 2'd0, 0, 0, 0, 1};
    tbl[10] = '{1'b0, 4'd0, 2'd0, 5, 1, 1, 0};
    tbl[11] = '{1'b0, 4'd0, 2'd0, 5, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, acc);
      chk("tbl_value", int'(value), tbl[i].ev);
      chk("tbl_value_valid", int'(value_valid), tbl[i].evv);
      chk("tbl_upd_pulse", int'(upd_pulse), tbl[i].eupd);
      chk("tbl_pending_cnt", int'(pending_cnt), tbl[i].epend);
    end

    // 3/MAX on edge 0, 7/MIN on edge 1: short one lands first, long overwrites.
    do_reset();
    pulses = 0;
    step(1'b1, 4'd3, 2'd2, acc);
    step(1'b1, 4'd7, 2'd0, acc);
    for (int k = 2; k <= 18; k++) begin
      step(1'b0, 4'd0, 2'd0, acc);
      if (upd_pulse) pulses++;
      if (k == 3)  chk("reorder_short_first", int'(value), 7);
      if (k == 17) chk("reorder_long_last", int'(value), 3);
    end
    chk("reorder_pulse_count", pulses, 2);

    // 4/MIN on edge 0 and 9/ZERO on edge 2 commit together; ZERO is younger.
    do_reset();
    step(1'b1, 4'd4, 2'd0, acc);
    step(1'b0, 4'd0, 2'd0, acc);
    step(1'b1, 4'd9, 2'd3, acc);
    chk("same_edge_youngest", int'(value), 9);
    chk("same_edge_pulse", int'(upd_pulse), 1);

    // Back-to-back MAX requests: four fill the pool, fifth waits until edge 18.
    do_reset();
    n_acc = 0;
    edge5 = -1;
    for (int k = 0; k < 40 && n_acc < 5; k++) begin
      step(1'b1, 4'(n_acc + 1), 2'd2, acc);
      if (acc) begin
        n_acc++;
        if (n_acc == 5) edge5 = k;
      end
      if (k == 5) begin
        chk("full_req_ready", int'(req_ready), 0);
        chk("full_pending_cnt", int'(pending_cnt), 4);
      end
    end
    chk("fifth_accept_edge", edge5, 18);

    // Reset mid-operation discards three pending TYP updates.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 4'(k + 1), 2'd1, acc);
    step(1'b0, 4'd0, 2'd0, acc);
    step(1'b0, 4'd0, 2'd0, acc);
    chk("pre_reset_pending", int'(pending_cnt), 3);
    do_reset();
    pulses = 0;
    for (int k = 6; k <= 14; k++) begin
      step(1'b0, 4'd0, 2'd0, acc);
      if (upd_pulse) pulses++;
    end
    chk("post_reset_no_commit", pulses, 0);
    chk("post_reset_value", int'(value), 0);

    // ZERO delay behaves like a nonblocking assign.
    do_reset();
    step(1'b1, 4'd2, 2'd3, acc);
    chk("zero_value", int'(value), 2);
    chk("zero_pending", int'(pending_cnt), 0);
    chk("zero_pulse", int'(upd_pulse), 1);
    step(1'b0, 4'd0, 2'd0, acc);
    chk("zero_pulse_drop", int'(upd_pulse), 0);

    // Random traffic against the model; a refused request is held stable.
    do_reset();
    hold = 1'b0;
    rv = 1'b0;
    rd = '0;
    rs = '0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        hold = 1'b0;
      end else begin
        if (!hold) begin
          rv = ($urandom_range(0, 9) < 7);
          rd = 4'($urandom);
          rs = 2'($urandom);
        end
        step(rv, rd, rs, acc);
        hold = rv && !acc;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
